slot_sequencer: RTL and testbench

SLOT_SEQUENCER -- requirements
Module: slot_sequencer

---
 rtl/slot_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_slot_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/slot_sequencer.sv
// ============================================================================
// Module   : slot_sequencer
// Brief    : Frame/slot timer driving a hit/gnd pulse burst, hush and listen
//            window per time slot.
// Revision : 1.0
// ============================================================================
`default_nettype none

module slot_sequencer #(
    parameter int NSLOT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [15:0] i_ts_time_0,
    input  logic [15:0] i_ts_time_1,
    input  logic [15:0] i_ts_time_2,
    input  logic [15:0] i_ts_time_3,
    input  logic [3:0]  i_pulse_mask,
    input  logic [7:0]  i_pulse_hit,
    input  logic [7:0]  i_pulse_gnd,
    input  logic [3:0]  i_pulse_count,
    input  logic [15:0] i_pulse_hush,
    output logic [1:0]  o_slot,
    output logic        o_slot_start,
    output logic [3:0]  o_hit,
    output logic [3:0]  o_gnd,
    output logic        o_hush,
    output logic        o_adc_en,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_HIT    = 3'd2,
        S_GND    = 3'd3,
        S_HUSH   = 3'd4,
        S_LISTEN = 3'd5
    } state_t;

    localparam logic [1:0] c_LAST_SLOT = 2'(NSLOT - 1);

    state_t      state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  pulses_q, pulses_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  hit_q, hit_d;
    logic [7:0]  gnd_q, gnd_d;
    logic [15:0] hush_q, hush_d;

    logic        slot_start_q;
    logic [3:0]  hit_en_q, gnd_en_q;
    logic        hush_en_q, adc_en_q, busy_q;

    logic        w_load;
    logic [15:0] w_ts;
    logic        w_expire;
    logic [1:0]  w_slot_next;
    logic [15:0] w_hush;
    logic        w_go_burst;
    logic        w_go_hush;
    logic [3:0]  w_pairs;

    assign w_load      = (state_q == S_LOAD);
    assign w_slot_next = (slot_q == c_LAST_SLOT) ? 2'd0 : slot_q + 2'd1;
    assign w_hush      = w_load ? i_pulse_hush : hush_q;

    always_comb begin
        w_ts = i_ts_time_0;
        case (slot_q)
            2'd0:    w_ts = i_ts_time_0;
            2'd1:    w_ts = i_ts_time_1;
            2'd2:    w_ts = i_ts_time_2;
            default: w_ts = i_ts_time_3;
        endcase
    end

    // In LOAD the timer is not yet loaded, so a 0/1-tick slot expires here.
    assign w_expire = w_load ? (w_ts <= 16'd1) : (timer_q == 16'd0);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        timer_d    = timer_q;
        phase_d    = phase_q;
        pulses_d   = pulses_q;
        mask_d     = w_load ? i_pulse_mask  : mask_q;
        hit_d      = w_load ? i_pulse_hit   : hit_q;
        gnd_d      = w_load ? i_pulse_gnd   : gnd_q;
        hush_d     = w_hush;
        w_go_burst = 1'b0;
        w_go_hush  = 1'b0;
        w_pairs    = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    state_d = S_LOAD;
                    slot_d  = 2'd0;
                end
            end
            default: begin
                if (w_expire) begin
                    timer_d  = 16'd0;
                    phase_d  = 8'd0;
                    pulses_d = 4'd0;
                    if (i_enable) begin
                        state_d = S_LOAD;
                        slot_d  = w_slot_next;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = w_load ? (w_ts - 16'd2) : (timer_q - 16'd1);
                    case (state_q)
                        S_LOAD: begin
                            w_go_burst = 1'b1;
                            w_pairs    = i_pulse_count;
                        end
                        S_HIT: begin
                            if (phase_q != 8'd0) begin
                                phase_d = phase_q - 8'd1;
                            end else if (gnd_q != 8'd0) begin
                                state_d = S_GND;
                                phase_d = gnd_q - 8'd1;
                            end else begin
                                w_go_burst = 1'b1;
                                w_pairs    = pulses_q;
                            end
                        end
                        S_GND: begin
                            if (phase_q != 8'd0) begin
                                phase_d = phase_q - 8'd1;
                            end else begin
                                w_go_burst = 1'b1;
                                w_pairs    = pulses_q;
                            end
                        end
                        S_HUSH: begin
                            if (hush_q != 16'd0) begin
                                hush_d = hush_q - 16'd1;
                            end else begin
                                state_d = S_LISTEN;
                            end
                        end
                        default: ;
                    endcase

                    // Start the next pair, skipping zero-length phases.
                    if (w_go_burst) begin
                        if (w_pairs == 4'd0) begin
                            w_go_hush = 1'b1;
                        end else if (hit_d != 8'd0) begin
                            state_d  = S_HIT;
                            phase_d  = hit_d - 8'd1;
                            pulses_d = w_pairs - 4'd1;
                        end else if (gnd_d != 8'd0) begin
                            state_d  = S_GND;
                            phase_d  = gnd_d - 8'd1;
                            pulses_d = w_pairs - 4'd1;
                        end else begin
                            w_go_hush = 1'b1;
                        end
                    end

                    if (w_go_hush) begin
                        if (w_hush != 16'd0) begin
                            state_d = S_HUSH;
                            hush_d  = w_hush - 16'd1;
                        end else begin
                            state_d = S_LISTEN;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            slot_q       <= 2'd0;
            timer_q      <= 16'd0;
            phase_q      <= 8'd0;
            pulses_q     <= 4'd0;
            mask_q       <= 4'd0;
            hit_q        <= 8'd0;
            gnd_q        <= 8'd0;
            hush_q       <= 16'd0;
            slot_start_q <= 1'b0;
            hit_en_q     <= 4'd0;
            gnd_en_q     <= 4'd0;
            hush_en_q    <= 1'b0;
            adc_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            timer_q      <= timer_d;
            phase_q      <= phase_d;
            pulses_q     <= pulses_d;
            mask_q       <= mask_d;
            hit_q        <= hit_d;
            gnd_q        <= gnd_d;
            hush_q       <= hush_d;
            slot_start_q <= (state_d == S_LOAD);
            hit_en_q     <= (state_d == S_HIT) ? mask_d : 4'd0;
            gnd_en_q     <= (state_d == S_GND) ? mask_d : 4'd0;
            hush_en_q    <= (state_d == S_HUSH);
            adc_en_q     <= (state_d == S_LISTEN);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign o_slot       = slot_q;
    assign o_slot_start = slot_start_q;
    assign o_hit        = hit_en_q;
    assign o_gnd        = gnd_en_q;
    assign o_hush       = hush_en_q;
    assign o_adc_en     = adc_en_q;
    assign o_busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_slot_sequencer.sv
// ============================================================================
// Module   : tb_slot_sequencer
// Brief    : Directed self-checking bench for slot_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_slot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [15:0] i_ts_time_0, i_ts_time_1, i_ts_time_2, i_ts_time_3;
    logic [3:0]  i_pulse_mask;
    logic [7:0]  i_pulse_hit, i_pulse_gnd;
    logic [3:0]  i_pulse_count;
    logic [15:0] i_pulse_hush;
    logic [1:0]  o_slot;
    logic        o_slot_start;
    logic [3:0]  o_hit, o_gnd;
    logic        o_hush, o_adc_en, o_busy;

    int          n_checks = 0;
    int          n_errors = 0;

    int          p_ts [4];
    int          p_hit, p_gnd, p_cnt, p_hush;
    logic [3:0]  p_mask;

    logic [13:0] dut_vec;

    slot_sequencer #(.NSLOT(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_ts_time_0  (i_ts_time_0),
        .i_ts_time_1  (i_ts_time_1),
        .i_ts_time_2  (i_ts_time_2),
        .i_ts_time_3  (i_ts_time_3),
        .i_pulse_mask (i_pulse_mask),
        .i_pulse_hit  (i_pulse_hit),
        .i_pulse_gnd  (i_pulse_gnd),
        .i_pulse_count(i_pulse_count),
        .i_pulse_hush (i_pulse_hush),
        .o_slot       (o_slot),
        .o_slot_start (o_slot_start),
        .o_hit        (o_hit),
        .o_gnd        (o_gnd),
        .o_hush       (o_hush),
        .o_adc_en     (o_adc_en),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // {slot_start, hit[3:0], gnd[3:0], hush, adc_en, busy, slot[1:0]}
    assign dut_vec = {o_slot_start, o_hit, o_gnd, o_hush, o_adc_en, o_busy, o_slot};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        i_ts_time_0   = 16'(p_ts[0]);
        i_ts_time_1   = 16'(p_ts[1]);
        i_ts_time_2   = 16'(p_ts[2]);
        i_ts_time_3   = 16'(p_ts[3]);
        i_pulse_mask  = p_mask;
        i_pulse_hit   = 8'(p_hit);
        i_pulse_gnd   = 8'(p_gnd);
        i_pulse_count = 4'(p_cnt);
        i_pulse_hush  = 16'(p_hush);
    endtask

    task automatic set_params(input int ts0, input int ts1, input int ts2, input int ts3,
                              input logic [3:0] mask, input int hit, input int gnd,
                              input int cnt, input int hush);
        p_ts[0] = ts0; p_ts[1] = ts1; p_ts[2] = ts2; p_ts[3] = ts3;
        p_mask = mask; p_hit = hit; p_gnd = gnd; p_cnt = cnt; p_hush = hush;
        apply();
    endtask

    // Expected outputs at tick t of a slot: burst of cnt (hit+gnd) pairs from
    // tick 1, then hush, then listen; the slot length truncates everything.
    function automatic logic [13:0] model(input int slot, input int t);
        int         per;
        int         b;
        logic [3:0] h, g;
        logic       hu, adc, st;
        per = p_hit + p_gnd;
        b   = p_cnt * per;
        h = 4'd0; g = 4'd0; hu = 1'b0; adc = 1'b0; st = 1'b0;
        if (t == 0) begin
            st = 1'b1;
        end else if (t - 1 < b) begin
            if (((t - 1) % per) < p_hit) h = p_mask;
            else                          g = p_mask;
        end else if (t - 1 < b + p_hush) begin
            hu = 1'b1;
        end else begin
            adc = 1'b1;
        end
        return {st, h, g, hu, adc, 1'b1, 2'(slot)};
    endfunction

    task automatic run_slot(input int slot, input int drop_t, input bit perturb);
        int len;
        len = (p_ts[slot] == 0) ? 1 : p_ts[slot];
        for (int t = 0; t < len; t++) begin
            tick();
            check($sformatf("slot%0d_t%0d", slot, t), 32'(dut_vec), 32'(model(slot, t)));
            if (t == drop_t) i_enable = 1'b0;
            if (perturb && t == 1) begin
                i_pulse_hit   = 8'd9;
                i_pulse_count = 4'd7;
                i_pulse_hush  = 16'd1;
                i_pulse_mask  = 4'hF;
                i_ts_time_0   = 16'd3;
                i_ts_time_1   = 16'd3;
                i_ts_time_2   = 16'd3;
                i_ts_time_3   = 16'd3;
            end
            if (perturb && t == len - 1) apply();
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_enable = 1'b0;
        tick();
        check("reset_state", 32'(dut_vec), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", 32'(dut_vec), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        i_enable = 1'b0;
        set_params(20, 20, 20, 20, 4'b0001, 2, 2, 2, 3);
        tick();
        do_reset();
        tick();
        check("idle_hold", 32'(dut_vec), 32'd0);

        // Basic frame, wrap 3->0, then enable drop in slot 2.
        i_enable = 1'b1;
        for (int s = 0; s < 7; s++) run_slot(s % 4, (s == 6) ? 3 : -1, 1'b0);
        tick();
        check("idle_keep_slot2", 32'(dut_vec), 32'd2);
        tick();
        check("idle_keep_slot2_b", 32'(dut_vec), 32'd2);

        // No burst, no hush; params scrambled mid-slot must not matter.
        set_params(10, 10, 10, 10, 4'b0001, 2, 2, 0, 0);
        i_enable = 1'b1;
        run_slot(0, -1, 1'b1);
        run_slot(1, -1, 1'b0);

        // Burst truncated by a short slot.
        set_params(6, 6, 6, 6, 4'b1010, 4, 4, 4, 3);
        do_reset();
        i_enable = 1'b1;
        run_slot(0, -1, 1'b0);
        run_slot(1, -1, 1'b0);
        run_slot(2, -1, 1'b0);

        // Zero-length slot 1: back-to-back slot starts.
        set_params(4, 0, 3, 3, 4'b0100, 1, 1, 1, 0);
        do_reset();
        i_enable = 1'b1;
        for (int s = 0; s < 5; s++) run_slot(s % 4, -1, 1'b0);

        // Asynchronous reset during HIT of slot 1.
        set_params(20, 20, 20, 20, 4'b0001, 2, 2, 2, 3);
        do_reset();
        i_enable = 1'b1;
        run_slot(0, -1, 1'b0);
        tick();
        check("s1_load", 32'(dut_vec), 32'(model(1, 0)));
        tick();
        check("s1_hit", 32'(o_hit), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_vec", 32'(dut_vec), 32'd0);
        tick();
        rst = 1'b0;
        run_slot(0, -1, 1'b0);
        run_slot(1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
